alu_arbiter: RTL and testbench

Round-robin arbiter that shares one combinational Hack ALU (x, y, zx/nx/zy/ny/f/no → out, zr, ng) among NUM_REQ requesters. Each requester presents operands and a control word with a valid/ready handshake. The arbiter latches the winner's operation, drives the shared ALU for one cycle, captures the result, and returns it with the requester's ID on a single response channel. It sits between the CPU-side units that need ALU cycles and the one ALU instance in the datapath.

---
 rtl/alu_arbiter.sv | 160 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Round-robin arbiter that shares one combinational Hack ALU among NUM_REQ
// requesters. A winner's operands are latched on accept, presented to the
// external ALU for one cycle (EXEC), and the captured result is returned on
// a single response channel together with the winner's index (RESP).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot)
//   req_x, req_y         packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ctrl             packed control words {zx,nx,zy,ny,f,no}, [i*6 +: 6]
//   alu_x/alu_y/alu_ctrl registered drive into the shared ALU
//   alu_out/alu_zr/alu_ng combinational result from the shared ALU
//   rsp_*                response channel (valid/ready, id, data, flags)
//   busy                 high whenever the FSM is not IDLE
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_x,
    input  logic [NUM_REQ*WIDTH-1:0] req_y,
    input  logic [NUM_REQ*6-1:0]     req_ctrl,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         alu_x,
    output logic [WIDTH-1:0]         alu_y,
    output logic [5:0]               alu_ctrl,
    input  logic [WIDTH-1:0]         alu_out,
    input  logic                     alu_zr,
    input  logic                     alu_ng,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_zr,
    output logic                     rsp_ng,
    input  logic                     rsp_ready,
    output logic                     busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q;
    logic [WIDTH-1:0] x_q, y_q;
    logic [5:0]       ctrl_q;
    logic [WIDTH-1:0] data_q;
    logic             zr_q, ng_q;

    logic [ID_W-1:0]  grant;
    logic             found;
    logic             accept;
    logic [ID_W:0]    scan_sum;
    logic [ID_W-1:0]  scan_idx;

    // Unpacked views of the packed request buses so the winner can be
    // selected with a plain array index.
    logic [WIDTH-1:0] x_arr    [NUM_REQ];
    logic [WIDTH-1:0] y_arr    [NUM_REQ];
    logic [5:0]       ctrl_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign x_arr[gi]    = req_x[gi*WIDTH +: WIDTH];
            assign y_arr[gi]    = req_y[gi*WIDTH +: WIDTH];
            assign ctrl_arr[gi] = req_ctrl[gi*6 +: 6];
        end
    endgenerate

    // Scan ptr, ptr+1, ... modulo NUM_REQ; the first valid requester wins.
    // The sum is one bit wider so the modulo wrap is a single subtract.
    always_comb begin
        found    = 1'b0;
        grant    = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (!found && req_valid[scan_idx]) begin
                found = 1'b1;
                grant = scan_idx;
            end
        end
    end

    // rst_n gates the accept so req_ready is held low for the whole time the
    // reset is asserted, not just after the first edge.
    assign accept = rst_n && (state_q == S_IDLE) && found;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_EXEC;
                    ptr_d   = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
                end
            end
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ctrl_q  <= '0;
            data_q  <= '0;
            zr_q    <= 1'b0;
            ng_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (accept) begin
                x_q    <= x_arr[grant];
                y_q    <= y_arr[grant];
                ctrl_q <= ctrl_arr[grant];
                id_q   <= grant;
            end
            if (state_q == S_EXEC) begin
                data_q <= alu_out;
                zr_q   <= alu_zr;
                ng_q   <= alu_ng;
            end
        end
    end

    assign alu_x     = x_q;
    assign alu_y     = y_q;
    assign alu_ctrl  = ctrl_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign rsp_zr    = zr_q;
    assign rsp_ng    = ng_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural Hack ALU attached.
module tb_alu_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_x;
    logic [N*W-1:0] req_y;
    logic [N*6-1:0] req_ctrl;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   alu_x, alu_y, alu_out;
    logic [5:0]     alu_ctrl;
    logic           alu_zr, alu_ng;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_zr, rsp_ng;
    logic           rsp_ready;
    logic           busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_ctrl(req_ctrl), .req_ready(req_ready),
        .alu_x(alu_x), .alu_y(alu_y), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_zr(rsp_zr), .rsp_ng(rsp_ng), .rsp_ready(rsp_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Hack ALU model: ctrl = {zx,nx,zy,ny,f,no}
    logic [W-1:0] mx1, mx2, my1, my2, mo;
    always_comb begin
        mx1     = alu_ctrl[5] ? '0 : alu_x;
        mx2     = alu_ctrl[4] ? ~mx1 : mx1;
        my1     = alu_ctrl[3] ? '0 : alu_y;
        my2     = alu_ctrl[2] ? ~my1 : my1;
        mo      = alu_ctrl[1] ? (mx2 + my2) : (mx2 & my2);
        alu_out = alu_ctrl[0] ? ~mo : mo;
        alu_zr  = (alu_out == '0);
        alu_ng  = alu_out[W-1];
    end

    logic [W-1:0] xs [N];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [5:0] c);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
        req_ctrl[i*6 +: 6] = c;
    endtask

    // One complete operation from an IDLE cycle; caller sets req_valid.
    task automatic run_op(input string tag, input logic [3:0] exp_rdy,
                          input logic [1:0] exp_id, input logic [W-1:0] exp_data,
                          input logic exp_zr, input logic exp_ng);
        check({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
        step();
        check({tag, ".exec_busy"}, 32'(busy), 32'd1);
        check({tag, ".exec_ready"}, 32'(req_ready), 32'd0);
        step();
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".rsp_id"}, 32'(rsp_id), 32'(exp_id));
        check({tag, ".rsp_data"}, 32'(rsp_data), 32'(exp_data));
        check({tag, ".rsp_zr"}, 32'(rsp_zr), 32'(exp_zr));
        check({tag, ".rsp_ng"}, 32'(rsp_ng), 32'(exp_ng));
        rsp_ready = 1'b1;
        step();
        check({tag, ".done"}, 32'(rsp_valid), 32'd0);
        $display("op %s id=%0d data=%h zr=%0b ng=%0b", tag, rsp_id, rsp_data, rsp_zr, rsp_ng);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_x     = '0;
        req_y     = '0;
        req_ctrl  = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            xs[i] = 16'h00A0 + 16'(i * 17);
            set_req(i, xs[i], xs[i], 6'b110000);
        end
        step();
        step();

        // Reset state, with every requester already valid
        check("rst.ready", 32'(req_ready), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.alu_x", 32'(alu_x), 32'd0);
        check("rst.alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("rst.rsp_data", 32'(rsp_data), 32'd0);
        $display("reset checked");
        rst_n = 1'b1;
        #1;

        // All requesters continuously valid: grant order 0,1,2,3,0
        run_op("all0", 4'b0001, 2'd0, xs[0], 1'b0, 1'b0);
        run_op("all1", 4'b0010, 2'd1, xs[1], 1'b0, 1'b0);
        run_op("all2", 4'b0100, 2'd2, xs[2], 1'b0, 1'b0);
        run_op("all3", 4'b1000, 2'd3, xs[3], 1'b0, 1'b0);
        run_op("all0b", 4'b0001, 2'd0, xs[0], 1'b0, 1'b0);
        req_valid = '0;
        #1;
        check("idle.ready", 32'(req_ready), 32'd0);

        // Single op: requester 2, 5 + 7 (ptr is 1)
        set_req(2, 16'd5, 16'd7, 6'b000010);
        req_valid = 4'b0100;
        #1;
        run_op("single", 4'b0100, 2'd2, 16'd12, 1'b0, 1'b0);
        req_valid = '0;

        // Backpressure: requester 1, 3 - 5 (ptr is 3, scan 3,0,1)
        set_req(1, 16'd3, 16'd5, 6'b010011);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        check("bp.ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b1111;
        step();
        for (int c = 0; c < 5; c++) begin
            check("bp.hold_valid", 32'(rsp_valid), 32'd1);
            check("bp.hold_data", 32'(rsp_data), 32'hFFFE);
            check("bp.hold_ng", 32'(rsp_ng), 32'd1);
            check("bp.hold_id", 32'(rsp_id), 32'd1);
            check("bp.hold_ready", 32'(req_ready), 32'd0);
            $display("bp hold cycle %0d valid=%0b data=%h", c, rsp_valid, rsp_data);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        check("bp.last_valid", 32'(rsp_valid), 32'd1);
        step();
        check("bp.done_valid", 32'(rsp_valid), 32'd0);
        check("bp.done_busy", 32'(busy), 32'd0);

        // Wrap and fairness (ptr is 2)
        req_valid = 4'b1000;
        #1;
        run_op("wrap3", 4'b1000, 2'd3, xs[3], 1'b0, 1'b0);
        req_valid = 4'b1001;
        #1;
        run_op("fair0", 4'b0001, 2'd0, xs[0], 1'b0, 1'b0);
        run_op("fair3", 4'b1000, 2'd3, xs[3], 1'b0, 1'b0);
        req_valid = '0;

        // Reset during EXEC drops the operation and clears ptr
        req_valid = 4'b0100;
        #1;
        check("rexec.ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        check("rexec.busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rexec.busy_rst", 32'(busy), 32'd0);
        check("rexec.alu_x", 32'(alu_x), 32'd0);
        check("rexec.alu_y", 32'(alu_y), 32'd0);
        check("rexec.alu_ctrl", 32'(alu_ctrl), 32'd0);
        check("rexec.rsp_data", 32'(rsp_data), 32'd0);
        check("rexec.rsp_id", 32'(rsp_id), 32'd0);
        check("rexec.rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("rexec.no_rsp", 32'(rsp_valid), 32'd0);
        end
        $display("reset in EXEC checked");

        // Zero result after reset: requesters 1 and 3 valid, ptr=0 picks 1
        set_req(1, 16'd9, 16'd9, 6'b010011);
        req_valid = 4'b1010;
        #1;
        run_op("zero", 4'b0010, 2'd1, 16'd0, 1'b1, 1'b0);
        req_valid = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
